icap_sequencer: RTL
===================

Name: icap_sequencer

Overview:
Owns the Artix-7 ICAPE2 primitive and shares it between two requesters. The reboot requester issues a warm boot (WBSTAR + IPROG). The status requester issues a configuration-register readback, e.g. BOOTSTS, WBSTAR or IDCODE.
Sits between the ZX-Uno register file (COREADDR/COREBOOT logic plus a new status-read register) and the ICAPE2 instance. It replaces the free-running command-ROM stepper.

Parameters:
RD_LATENCY, 3, cycles CSIB is held low in read mode; icap_o is sampled on the last of these cycles.
NOP_TAIL, 4, NOP words appended after IPROG.

Ports:
clk  in  1  ICAP clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
boot_req  in  1  one-cycle pulse: warm reboot requested.
boot_addr  in  24  flash address bits [31:8]; sampled when the reboot request is latched.
rd_req  in  1  level: readback requested; held high until rd_valid.
rd_reg  in  5  configuration register address; sampled on acceptance.
rd_data  out  32  captured register value, natural bit order.
rd_valid  out  1  one-cycle pulse; rd_data is valid.
busy  out  1  high whenever the FSM is not IDLE.
icap_csib  out  1  ICAPE2 CSIB, active low.
icap_rdwrb  out  1  ICAPE2 RDWRB; 0 = write, 1 = read.
icap_i  out  32  ICAPE2 I, already bit-swapped.
icap_o  in  32  ICAPE2 O, raw (un-swapped).

Behaviour:
- Reset values: icap_csib=1, icap_rdwrb=0, icap_i=swap(FFFFFFFF), rd_data=0, rd_valid=0, busy=0, pending boot cleared, FSM=IDLE. Reset mid-sequence aborts immediately to these values.
- Word convention: all words below are natural bitstream words. Output is registered: a word chosen in cycle n appears on icap_i in cycle n+1.
- boot_req latching: sets a pending-boot flag and captures boot_addr in any state except BOOTED. A later pulse before service overwrites the address.
- Arbitration in IDLE: pending boot beats rd_req. Simultaneous boot_req and rd_req → boot path, and the read is never accepted.
- Boot during a read: the read finishes completely (including desync). The FSM returns to IDLE for one cycle, then takes the boot.
- States: IDLE, WR_SEQ, RD_HDR, RD_TURN1, RD_TURN2, RD_WAIT, RD_BACK1, RD_BACK2, RD_DESYNC, BOOTED.
- WR_SEQ, one word per cycle:
  - FFFFFFFF with CSIB=1.
  - Then with CSIB=0, RDWRB=0: AA995566, 20000000, 30020001, {8'h00,boot_addr}, 30008001, 0000000F, then NOP_TAIL × 20000000.
  - Then → BOOTED.
- BOOTED: CSIB=1; terminal until rst; all requests ignored.
- RD_HDR, one word per cycle:
  - FFFFFFFF with CSIB=1.
  - Then with CSIB=0: AA995566, 20000000, 20000000, 28000001 | (rd_reg<<13), 20000000, 20000000.
- RD_TURN1: CSIB=1, RDWRB=0.
- RD_TURN2: CSIB=1, RDWRB=1. RDWRB never changes while CSIB=0.
- RD_WAIT: CSIB=0, RDWRB=1 for RD_LATENCY cycles. On the last cycle, rd_data ← unswap(icap_o).
- RD_BACK1: CSIB=1, RDWRB=1.
- RD_BACK2: CSIB=1, RDWRB=0.
- RD_DESYNC: CSIB=0, RDWRB=0, words 30008001, 0000000D, 20000000, 20000000.
- Completion: CSIB=1, rd_valid pulses, → IDLE. rd_req must drop the cycle after rd_valid; if still high, a new read is accepted.
- Step counter: 4 bits, resets on every state entry. An out-of-range rd_reg is not checked and is sent as given.

Optional Feature:
ICAP_READBACK_EN.
- Defined: full read path as above.
- Undefined: RD_* states and the icap_o capture are not built. rd_req is ignored; rd_data=0 and rd_valid=0 always; icap_rdwrb is tied to 0.

Decomposition:
Package icap_pkg holds:
- the state enum;
- localparams SYNC_WORD=AA995566, NOP=20000000, DUMMY=FFFFFFFF, HDR_WR_WBSTAR=30020001, HDR_WR_CMD=30008001, CMD_IPROG=0000000F, CMD_DESYNC=0000000D, HDR_RD_BASE=28000001;
- register addresses REG_WBSTAR=5'h10, REG_IDCODE=5'h0C, REG_BOOTSTS=5'h16.

Sub-module icap_bitswap (combinational): per-byte bit reversal, used on both icap_i and icap_o.

Test Plan:
1. rst low, boot_req pulse with boot_addr=100000 → unswapped icap_i sequence: FFFFFFFF(CSIB=1), AA995566, 20000000, 30020001, 00100000, 30008001, 0000000F, 4× 20000000; then CSIB=1 held; busy stays 1.
2. rd_req with rd_reg=0C; model returns swap(13631093) when CSIB=0 and RDWRB=1 → header word 28018001; rd_valid one cycle with rd_data=13631093; RDWRB toggles only while CSIB=1; desync words present.
3. boot_req and rd_req in the same IDLE cycle → boot sequence only; rd_valid never asserted.
4. boot_req (addr=200000) during RD_WAIT → read completes with rd_valid, then one IDLE cycle, then the boot sequence carries 00200000.
5. rst asserted at WR_SEQ step 4 → next cycle CSIB=1, icap_i=swap(FFFFFFFF), busy=0; a new boot_req then gives the full sequence again.
6. Build without ICAP_READBACK_EN, rd_req=1 for 50 cycles → busy=0, CSIB=1, rd_valid=0.

Source files
------------

// File: rtl/icap_pkg.sv
// Shared types and bitstream constants for the ICAPE2 sequencer.
// The optional read path is enabled by defining ICAP_READBACK_EN.
package icap_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_SEQ,
    ST_RD_HDR,
    ST_RD_TURN1,
    ST_RD_TURN2,
    ST_RD_WAIT,
    ST_RD_BACK1,
    ST_RD_BACK2,
    ST_RD_DESYNC,
    ST_BOOTED
  } state_t;

  localparam logic [31:0] SYNC_WORD     = 32'hAA995566;
  localparam logic [31:0] NOP           = 32'h20000000;
  localparam logic [31:0] DUMMY         = 32'hFFFFFFFF;
  localparam logic [31:0] HDR_WR_WBSTAR = 32'h30020001;
  localparam logic [31:0] HDR_WR_CMD    = 32'h30008001;
  localparam logic [31:0] CMD_IPROG     = 32'h0000000F;
  localparam logic [31:0] CMD_DESYNC    = 32'h0000000D;
  localparam logic [31:0] HDR_RD_BASE   = 32'h28000001;

  localparam logic [4:0] REG_WBSTAR  = 5'h10;
  localparam logic [4:0] REG_IDCODE  = 5'h0C;
  localparam logic [4:0] REG_BOOTSTS = 5'h16;

  // Steps past the IPROG command fall through to the NOP tail.
  function automatic logic [31:0] boot_word(input logic [3:0] step, input logic [23:0] addr);
    case (step)
      4'd0:    return DUMMY;
      4'd1:    return SYNC_WORD;
      4'd2:    return NOP;
      4'd3:    return HDR_WR_WBSTAR;
      4'd4:    return {8'h00, addr};
      4'd5:    return HDR_WR_CMD;
      4'd6:    return CMD_IPROG;
      default: return NOP;
    endcase
  endfunction

  function automatic logic [31:0] read_hdr_word(input logic [3:0] step, input logic [4:0] cfg_reg);
    case (step)
      4'd0:    return DUMMY;
      4'd1:    return SYNC_WORD;
      4'd4:    return HDR_RD_BASE | (32'(cfg_reg) << 13);
      default: return NOP;
    endcase
  endfunction

  function automatic logic [31:0] desync_word(input logic [3:0] step);
    case (step)
      4'd0:    return HDR_WR_CMD;
      4'd1:    return CMD_DESYNC;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/icap_bitswap.sv
// Per-byte bit reversal between natural bitstream order and the ICAPE2 pin order.
// Self-inverse, so the same block serves both the I and O buses.
module icap_bitswap (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar gi = 0; gi < 32; gi++) begin : g_bit
    assign dout[gi] = din[(gi / 8) * 8 + 7 - (gi % 8)];
  end

endmodule

// File: rtl/icap_sequencer.sv
// Arbitrates the ICAPE2 between warm-boot (WBSTAR + IPROG) and config-register readback.
// The readback path is only built when ICAP_READBACK_EN is defined.
module icap_sequencer
  import icap_pkg::*;
#(
  parameter int RD_LATENCY = 3,
  parameter int NOP_TAIL   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        boot_req,
  input  logic [23:0] boot_addr,
  input  logic        rd_req,
  input  logic [4:0]  rd_reg,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic [31:0] icap_o
);

  localparam logic [3:0] WR_LAST = 4'(6 + NOP_TAIL);

  state_t      state_reg;
  logic [3:0]  step_reg;
  logic        boot_pend_reg;
  logic [23:0] boot_addr_reg;
  logic        csib_reg;
  logic [31:0] icap_word_reg;

`ifdef ICAP_READBACK_EN
  localparam logic [3:0] WAIT_LAST = 4'(RD_LATENCY - 1);

  logic        rdwrb_reg;
  logic [4:0]  rd_reg_reg;
  logic [31:0] rd_data_reg;
  logic        rd_valid_reg;
  logic [31:0] icap_o_nat;

  icap_bitswap u_swap_o (.din(icap_o), .dout(icap_o_nat));

  assign rd_data    = rd_data_reg;
  assign rd_valid   = rd_valid_reg;
  assign icap_rdwrb = rdwrb_reg;
`else
  localparam int unused_rd_latency = RD_LATENCY;
  logic unused_rd;
  assign unused_rd  = ^{rd_req, rd_reg, icap_o};
  assign rd_data    = '0;
  assign rd_valid   = 1'b0;
  assign icap_rdwrb = 1'b0;
`endif

  icap_bitswap u_swap_i (.din(icap_word_reg), .dout(icap_i));

  assign icap_csib = csib_reg;
  assign busy      = (state_reg != ST_IDLE);

  // Outputs are registered from the current state/step, so each word lands one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      step_reg      <= '0;
      boot_pend_reg <= 1'b0;
      boot_addr_reg <= '0;
      csib_reg      <= 1'b1;
      icap_word_reg <= DUMMY;
`ifdef ICAP_READBACK_EN
      rdwrb_reg     <= 1'b0;
      rd_reg_reg    <= '0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
`endif
    end else begin
      step_reg <= step_reg + 4'd1;
`ifdef ICAP_READBACK_EN
      rd_valid_reg <= 1'b0;
`endif
      if (boot_req && state_reg != ST_BOOTED) begin
        boot_pend_reg <= 1'b1;
        boot_addr_reg <= boot_addr;
      end
      case (state_reg)
        ST_IDLE: begin
          csib_reg      <= 1'b1;
          icap_word_reg <= DUMMY;
          step_reg      <= '0;
          if (boot_req || boot_pend_reg) begin
            boot_pend_reg <= 1'b0;
            state_reg     <= ST_WR_SEQ;
`ifdef ICAP_READBACK_EN
          // The rd_valid cycle is skipped so a requester that drops rd_req on time is not re-served.
          end else if (rd_req && !rd_valid_reg) begin
            rd_reg_reg <= rd_reg;
            state_reg  <= ST_RD_HDR;
`endif
          end
        end
        ST_WR_SEQ: begin
          csib_reg      <= (step_reg == 4'd0);
          icap_word_reg <= boot_word(step_reg, boot_addr_reg);
          if (step_reg == WR_LAST) begin
            state_reg <= ST_BOOTED;
            step_reg  <= '0;
          end
        end
        ST_BOOTED: begin
          csib_reg      <= 1'b1;
          icap_word_reg <= DUMMY;
          step_reg      <= '0;
        end
`ifdef ICAP_READBACK_EN
        ST_RD_HDR: begin
          csib_reg      <= (step_reg == 4'd0);
          icap_word_reg <= read_hdr_word(step_reg, rd_reg_reg);
          if (step_reg == 4'd6) begin
            state_reg <= ST_RD_TURN1;
            step_reg  <= '0;
          end
        end
        ST_RD_TURN1: begin
          csib_reg      <= 1'b1;
          rdwrb_reg     <= 1'b0;
          icap_word_reg <= DUMMY;
          state_reg     <= ST_RD_TURN2;
          step_reg      <= '0;
        end
        ST_RD_TURN2: begin
          csib_reg  <= 1'b1;
          rdwrb_reg <= 1'b1;
          state_reg <= ST_RD_WAIT;
          step_reg  <= '0;
        end
        ST_RD_WAIT: begin
          csib_reg  <= 1'b0;
          rdwrb_reg <= 1'b1;
          if (step_reg == WAIT_LAST) begin
            state_reg <= ST_RD_BACK1;
            step_reg  <= '0;
          end
        end
        ST_RD_BACK1: begin
          csib_reg    <= 1'b1;
          rdwrb_reg   <= 1'b1;
          rd_data_reg <= icap_o_nat;
          state_reg   <= ST_RD_BACK2;
          step_reg    <= '0;
        end
        ST_RD_BACK2: begin
          csib_reg  <= 1'b1;
          rdwrb_reg <= 1'b0;
          state_reg <= ST_RD_DESYNC;
          step_reg  <= '0;
        end
        ST_RD_DESYNC: begin
          if (step_reg == 4'd4) begin
            csib_reg      <= 1'b1;
            icap_word_reg <= DUMMY;
            rd_valid_reg  <= 1'b1;
            state_reg     <= ST_IDLE;
            step_reg      <= '0;
          end else begin
            csib_reg      <= 1'b0;
            rdwrb_reg     <= 1'b0;
            icap_word_reg <= desync_word(step_reg);
          end
        end
`endif
        default: begin
          csib_reg  <= 1'b1;
          state_reg <= ST_IDLE;
          step_reg  <= '0;
        end
      endcase
    end
  end

endmodule
